// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - pedestrian crossing controller with walk, flashing walk and night flash
//
// Purpose: sequences a three-aspect vehicle signal and a two-aspect pedestrian
// signal. Pedestrian requests are latched; the vehicle phase is taken through
// yellow and all-red clearance before walk, followed by flashing walk and a
// further all-red before green. Night mode flashes vehicle yellow with the
// pedestrian signal dark. All phases are timed in ticks of an internal prescaler.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   ped_req      pedestrian button level (already synchronised/debounced)
//   night        night/flash mode request (acted on only in CAR_GREEN)
//   car_red      vehicle red lamp
//   car_yellow   vehicle yellow lamp
//   car_green    vehicle green lamp
//   ped_red      pedestrian red lamp
//   ped_green    pedestrian walk lamp
//   walk_count   ticks remaining in WALK/PED_FLASH, 0 elsewhere
//   req_pending  latched pedestrian request

module ped_crossing_ctrl #(
  parameter int CLK_DIV     = 50_000_000,
  parameter int T_GREEN_MIN = 10,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 1,
  parameter int T_WALK      = 8,
  parameter int T_FLASH     = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_req,
  input  logic             night,
  output logic             car_red,
  output logic             car_yellow,
  output logic             car_green,
  output logic             ped_red,
  output logic             ped_green,
  output logic [CNT_W-1:0] walk_count,
  output logic             req_pending
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    RED_EXIT   = 3'd0,
    CAR_GREEN  = 3'd1,
    CAR_YELLOW = 3'd2,
    RED_ENTRY  = 3'd3,
    WALK       = 3'd4,
    PED_FLASH  = 3'd5,
    NIGHT      = 3'd6
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] load_val;
  logic             phase_q;
  logic             tick;
  logic             trans;
  logic             timer_last;

  assign tick       = (presc_q == PW'(CLK_DIV - 1));
  assign trans      = (state_nxt != state_q);
  assign timer_last = tick && (timer_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RED_EXIT;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      RED_EXIT:   if (timer_last) state_nxt = CAR_GREEN;
      CAR_GREEN: begin
        // night takes priority over a pending request
        if (night)                                state_nxt = NIGHT;
        else if (timer_q == '0 && req_pending)    state_nxt = CAR_YELLOW;
      end
      CAR_YELLOW: if (timer_last) state_nxt = RED_ENTRY;
      RED_ENTRY:  if (timer_last) state_nxt = WALK;
      WALK:       if (timer_last) state_nxt = PED_FLASH;
      PED_FLASH:  if (timer_last) state_nxt = RED_EXIT;
      NIGHT:      if (!night)     state_nxt = RED_EXIT;
      default:    state_nxt = RED_EXIT;
    endcase
  end

  // Lamp decode from registered state and phase only
  always_comb begin
    car_red    = 1'b0;
    car_yellow = 1'b0;
    car_green  = 1'b0;
    ped_red    = 1'b0;
    ped_green  = 1'b0;
    walk_count = '0;
    unique case (state_q)
      RED_EXIT:   begin car_red = 1'b1;    ped_red = 1'b1; end
      CAR_GREEN:  begin car_green = 1'b1;  ped_red = 1'b1; end
      CAR_YELLOW: begin car_yellow = 1'b1; ped_red = 1'b1; end
      RED_ENTRY:  begin car_red = 1'b1;    ped_red = 1'b1; end
      WALK:       begin car_red = 1'b1; ped_green = 1'b1;   walk_count = timer_q; end
      PED_FLASH:  begin car_red = 1'b1; ped_green = phase_q; walk_count = timer_q; end
      NIGHT:      car_yellow = phase_q;
      default:    begin car_red = 1'b1;    ped_red = 1'b1; end
    endcase
  end

  // Duration of the state being entered
  always_comb begin
    load_val = '0;
    unique case (state_nxt)
      RED_EXIT, RED_ENTRY: load_val = CNT_W'(T_ALL_RED);
      CAR_GREEN:           load_val = CNT_W'(T_GREEN_MIN);
      CAR_YELLOW:          load_val = CNT_W'(T_YELLOW);
      WALK:                load_val = CNT_W'(T_WALK);
      PED_FLASH:           load_val = CNT_W'(T_FLASH);
      default:             load_val = '0;
    endcase
  end

  // Prescaler restarts on every state change so each timed state is whole ticks
  always_ff @(posedge clk) begin
    if (rst)                presc_q <= '0;
    else if (trans || tick) presc_q <= '0;
    else                    presc_q <= presc_q + 1'b1;
  end

  // Phase timer: loaded on entry, counts ticks down and saturates at 0
  always_ff @(posedge clk) begin
    if (rst)                       timer_q <= CNT_W'(T_ALL_RED);
    else if (trans)                timer_q <= load_val;
    else if (tick && timer_q != '0) timer_q <= timer_q - 1'b1;
  end

  // Flash phase: starts lit on entry to PED_FLASH/NIGHT, toggles per tick
  always_ff @(posedge clk) begin
    if (rst)
      phase_q <= 1'b0;
    else if (trans && (state_nxt == PED_FLASH || state_nxt == NIGHT))
      phase_q <= 1'b1;
    else if (tick && (state_q == PED_FLASH || state_q == NIGHT))
      phase_q <= ~phase_q;
  end

  // Request latch: clearing on WALK/NIGHT entry wins over a same-cycle press
  always_ff @(posedge clk) begin
    if (rst)
      req_pending <= 1'b0;
    else if (state_q == NIGHT || state_nxt == NIGHT ||
             (state_nxt == WALK && state_q != WALK))
      req_pending <= 1'b0;
    else if (ped_req && (state_q == RED_EXIT || state_q == CAR_GREEN ||
                         state_q == CAR_YELLOW || state_q == RED_ENTRY))
      req_pending <= 1'b1;
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - scoreboard bench for ped_crossing_ctrl

module tb_ped_crossing_ctrl;

    logic       clk;
    logic       rst;
    logic       ped_req;
    logic       night;
    logic       car_red, car_yellow, car_green, ped_red, ped_green;
    logic [7:0] walk_count;
    logic       req_pending;

    ped_crossing_ctrl #(
        .CLK_DIV(4), .T_GREEN_MIN(5), .T_YELLOW(2), .T_ALL_RED(1),
        .T_WALK(3), .T_FLASH(2), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .night(night),
        .car_red(car_red), .car_yellow(car_yellow), .car_green(car_green),
        .ped_red(ped_red), .ped_green(ped_green),
        .walk_count(walk_count), .req_pending(req_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] L_RED  = 5'b10010;
    localparam logic [4:0] L_GRN  = 5'b00110;
    localparam logic [4:0] L_YEL  = 5'b01010;
    localparam logic [4:0] L_WALK = 5'b10001;
    localparam logic [4:0] L_FOFF = 5'b10000;
    localparam logic [4:0] L_NY   = 5'b01000;
    localparam logic [4:0] L_DARK = 5'b00000;

    typedef struct {
        logic [13:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic [13:0] act;
    int vectors = 0;
    int pushed = 0;
    int miscompares = 0;
    logic night_state = 1'b0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            act = {car_red, car_yellow, car_green, ped_red, ped_green, req_pending, walk_count};
            vectors++;
            night_state = (cur.v[13:9] == L_NY) || (cur.v[13:9] == L_DARK);
            if (act !== cur.v) begin
                miscompares++;
                $display("FAIL %s @%0t: got lamps=%b req=%b wc=%0d, want lamps=%b req=%b wc=%0d",
                         cur.tag, $time, act[13:9], act[8], act[7:0],
                         cur.v[13:9], cur.v[8], cur.v[7:0]);
            end
            if (car_green === 1'b1 && ped_green === 1'b1) begin
                miscompares++;
                $display("FAIL %s @%0t: car_green and ped_green both lit", cur.tag, $time);
            end
            if (!night_state && (car_red + car_yellow + car_green) != 1) begin
                miscompares++;
                $display("FAIL %s @%0t: vehicle lamps not exclusive", cur.tag, $time);
            end
        end
    end

    task automatic cyc(input logic [4:0] lamps, input logic req,
                       input logic [7:0] wc, input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.v   = {lamps, req, wc};
            e.tag = tag;
            exp_q.push_back(e);
            pushed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic walk_flash();
        cyc(L_WALK, 1'b0, 8'd3, 4, "walk3");
        cyc(L_WALK, 1'b0, 8'd2, 4, "walk2");
        cyc(L_WALK, 1'b0, 8'd1, 4, "walk1");
        cyc(L_WALK, 1'b0, 8'd2, 4, "flash_on");
        cyc(L_FOFF, 1'b0, 8'd1, 4, "flash_off");
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ped_req = 1'b0; night = 1'b0;
        @(posedge clk); #1;
        cyc(L_RED, 1'b0, 8'd0, 1, "in_reset");
        rst = 1'b0;
        cyc(L_RED, 1'b0, 8'd0, 4, "reset_red_exit");
        cyc(L_GRN, 1'b0, 8'd0, 200, "green_hold");
        ped_req = 1'b1; cyc(L_GRN, 1'b0, 8'd0, 1, "late_req_press");
        ped_req = 1'b0; cyc(L_GRN, 1'b1, 8'd0, 1, "late_req_latched");
        cyc(L_YEL, 1'b1, 8'd0, 8, "yellow");
        cyc(L_RED, 1'b1, 8'd0, 4, "red_entry");
        walk_flash();
        cyc(L_RED, 1'b0, 8'd0, 4, "red_exit");
        cyc(L_GRN, 1'b0, 8'd0, 2, "s2_green_early");
        ped_req = 1'b1; cyc(L_GRN, 1'b0, 8'd0, 1, "s2_press");
        ped_req = 1'b0; cyc(L_GRN, 1'b1, 8'd0, 18, "s2_green_min");
        cyc(L_YEL, 1'b1, 8'd0, 8, "s2_yellow");
        cyc(L_RED, 1'b1, 8'd0, 4, "s2_red_entry");
        ped_req = 1'b1; walk_flash();
        ped_req = 1'b0; cyc(L_RED, 1'b0, 8'd0, 4, "s3_red_exit");
        cyc(L_GRN, 1'b0, 8'd0, 60, "s3_green_hold");
        ped_req = 1'b1; cyc(L_GRN, 1'b0, 8'd0, 1, "s4_press");
        ped_req = 1'b0; night = 1'b1; cyc(L_GRN, 1'b1, 8'd0, 1, "s4_night_vs_req");
        ped_req = 1'b1;
        cyc(L_NY,   1'b0, 8'd0, 4, "s4_night_on1");
        cyc(L_DARK, 1'b0, 8'd0, 4, "s4_night_off1");
        cyc(L_NY,   1'b0, 8'd0, 4, "s4_night_on2");
        ped_req = 1'b0;
        cyc(L_DARK, 1'b0, 8'd0, 3, "s4_night_off2");
        night = 1'b0; cyc(L_DARK, 1'b0, 8'd0, 1, "s4_night_release");
        cyc(L_RED, 1'b0, 8'd0, 4, "s4_red_exit");
        cyc(L_GRN, 1'b0, 8'd0, 1, "s6_g0");
        ped_req = 1'b1; cyc(L_GRN, 1'b0, 8'd0, 1, "s6_press");
        ped_req = 1'b0; cyc(L_GRN, 1'b1, 8'd0, 19, "s6_green_min");
        cyc(L_YEL, 1'b1, 8'd0, 2, "s6_yellow_a");
        night = 1'b1; cyc(L_YEL, 1'b1, 8'd0, 6, "s6_yellow_night");
        cyc(L_RED, 1'b1, 8'd0, 4, "s6_red_entry");
        walk_flash();
        cyc(L_RED, 1'b0, 8'd0, 4, "s6_red_exit");
        cyc(L_GRN, 1'b0, 8'd0, 1, "s6_green_one");
        cyc(L_NY,   1'b0, 8'd0, 4, "s6_night_on");
        cyc(L_DARK, 1'b0, 8'd0, 3, "s6_night_off");
        night = 1'b0; cyc(L_DARK, 1'b0, 8'd0, 1, "s6_night_release");
        cyc(L_RED, 1'b0, 8'd0, 4, "s6_red_exit2");
        ped_req = 1'b1; cyc(L_GRN, 1'b0, 8'd0, 1, "s5_press");
        ped_req = 1'b0; cyc(L_GRN, 1'b1, 8'd0, 20, "s5_green_min");
        cyc(L_YEL, 1'b1, 8'd0, 8, "s5_yellow");
        cyc(L_RED, 1'b1, 8'd0, 4, "s5_red_entry");
        cyc(L_WALK, 1'b0, 8'd3, 4, "s5_walk3");
        cyc(L_WALK, 1'b0, 8'd2, 1, "s5_walk2");
        rst = 1'b1; cyc(L_WALK, 1'b0, 8'd2, 1, "s5_rst_pulse");
        rst = 1'b0; cyc(L_RED, 1'b0, 8'd0, 4, "s5_after_reset");
        cyc(L_GRN, 1'b0, 8'd0, 30, "s5_green_hold");
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations never checked", exp_q.size());
        end
        if (vectors != pushed) begin
            miscompares++;
            $display("FAIL count: %0d vectors applied, %0d queued", vectors, pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0)
            $display("PASS");
        else
            $display("FAIL");
        $finish;
    end

endmodule
